// File: rtl/rr_mux2_arbiter.sv
// Round-robin 2:1 stream mux with one registered output stage.
// Rotating priority picks the winner of each transfer, and the winning channel is exported on out_sel.
module rr_mux2_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in0_data,
   input  logic             in0_valid,
   output logic             in0_ready,
   input  logic [WIDTH-1:0] in1_data,
   input  logic             in1_valid,
   output logic             in1_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sel,
   output logic             prio
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t state;
   state_t state_next;

   logic can_accept;
   logic any_valid;
   logic grant;
   logic take0;
   logic take1;
   logic xfer;

   // Handshakes: a word moves on a channel when valid & ready are both high at a clk edge.
   // Producers hold valid and data until accepted. Ready may follow the other channel's
   // valid but never this channel's own data. The output stage reloads while it drains.
   always_comb begin
      can_accept = 1'b0;
      any_valid  = 1'b0;
      grant      = 1'b0;
      in0_ready  = 1'b0;
      in1_ready  = 1'b0;
      take0      = 1'b0;
      take1      = 1'b0;
      xfer       = 1'b0;
      state_next = state;

      can_accept = (state == EMPTY) | (out_valid & out_ready);
      any_valid  = in0_valid | in1_valid;
      grant      = (in0_valid & in1_valid) ? prio : in1_valid;
      in0_ready  = can_accept & any_valid & ~grant;
      in1_ready  = can_accept & any_valid & grant;
      take0      = in0_valid & in0_ready;
      take1      = in1_valid & in1_ready;
      xfer       = take0 | take1;

      if (xfer) begin
         state_next = FULL;
      end else if ((state == FULL) && out_ready) begin
         state_next = EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // The payload, its source and the rotating priority change only on an accepted transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data <= '0;
         out_sel  <= 1'b0;
         prio     <= 1'b0;
      end else if (xfer) begin
         out_data <= take1 ? in1_data : in0_data;
         out_sel  <= take1;
         prio     <= ~take1;
      end
   end

   assign out_valid = (state == FULL);

endmodule

// File: tb/tb_rr_mux2_arbiter.sv
// Directed bench for rr_mux2_arbiter: reset, single channel, contention, backpressure,
// drain to empty and asynchronous reset, each checked against hand-computed values.
module tb_rr_mux2_arbiter;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] in0_data;
   logic             in0_valid;
   logic             in0_ready;
   logic [WIDTH-1:0] in1_data;
   logic             in1_valid;
   logic             in1_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_sel;
   logic             prio;

   int n_cmp;
   int n_err;

   rr_mux2_arbiter #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in0_data  (in0_data),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in1_data  (in1_data),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sel   (out_sel),
      .prio      (prio)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timed out");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then sample on the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [WIDTH-1:0] seq_data [4];
   logic             seq_sel  [4];

   initial begin
      n_cmp = 0;
      n_err = 0;
      seq_data[0] = 8'h11; seq_data[1] = 8'h22; seq_data[2] = 8'h11; seq_data[3] = 8'h22;
      seq_sel[0]  = 1'b0;  seq_sel[1]  = 1'b1;  seq_sel[2]  = 1'b0;  seq_sel[3]  = 1'b1;

      rst = 1'b1;
      in0_data = '0; in0_valid = 1'b0;
      in1_data = '0; in1_valid = 1'b0;
      out_ready = 1'b0;

      // Reset then idle
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data",  out_data,  8'h00);
      chk("rst_out_sel",   out_sel,   1'b0);
      chk("rst_prio",      prio,      1'b0);
      chk("idle_in0_ready", in0_ready, 1'b0);
      chk("idle_in1_ready", in1_ready, 1'b0);
      step();
      chk("idle_out_valid", out_valid, 1'b0);

      // Single channel 1 word
      in1_valid = 1'b1; in1_data = 8'hA5; out_ready = 1'b1;
      #1;
      chk("single_in1_ready", in1_ready, 1'b1);
      chk("single_in0_ready", in0_ready, 1'b0);
      step();
      in1_valid = 1'b0;
      chk("single_out_data",  out_data,  8'hA5);
      chk("single_out_sel",   out_sel,   1'b1);
      chk("single_out_valid", out_valid, 1'b1);
      chk("single_prio",      prio,      1'b0);
      step();
      chk("single_drain_valid", out_valid, 1'b0);
      chk("single_drain_data",  out_data,  8'hA5);

      // Contention from a fresh reset
      rst = 1'b1;
      #1;
      rst = 1'b0;
      in0_valid = 1'b1; in0_data = 8'h11;
      in1_valid = 1'b1; in1_data = 8'h22;
      out_ready = 1'b1;
      #1;
      chk("cont_first_in0_ready", in0_ready, 1'b1);
      chk("cont_first_in1_ready", in1_ready, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("cont_data_%0d", i),  out_data,  seq_data[i]);
         chk($sformatf("cont_sel_%0d", i),   out_sel,   seq_sel[i]);
         chk($sformatf("cont_valid_%0d", i), out_valid, 1'b1);
      end
      chk("cont_prio_end", prio, 1'b0);

      // Backpressure: load 0x3C from channel 0 alone, then stall
      in1_valid = 1'b0; in0_data = 8'h3C;
      step();
      chk("bp_load_data", out_data, 8'h3C);
      chk("bp_load_prio", prio,     1'b1);
      out_ready = 1'b0;
      in0_valid = 1'b1; in0_data = 8'h44;
      in1_valid = 1'b1; in1_data = 8'h99;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("bp_in0_ready_%0d", i), in0_ready, 1'b0);
         chk($sformatf("bp_in1_ready_%0d", i), in1_ready, 1'b0);
         step();
         chk($sformatf("bp_data_%0d", i),  out_data,  8'h3C);
         chk($sformatf("bp_valid_%0d", i), out_valid, 1'b1);
         chk($sformatf("bp_prio_%0d", i),  prio,      1'b1);
         chk($sformatf("bp_sel_%0d", i),   out_sel,   1'b0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_in1_ready", in1_ready, 1'b1);
      chk("bp_release_in0_ready", in0_ready, 1'b0);
      step();
      chk("bp_next_data",  out_data,  8'h99);
      chk("bp_next_sel",   out_sel,   1'b1);
      chk("bp_next_valid", out_valid, 1'b1);
      chk("bp_next_prio",  prio,      1'b0);

      // Drain to empty after one word 0x7E
      in1_valid = 1'b0; in0_valid = 1'b1; in0_data = 8'h7E;
      step();
      in0_valid = 1'b0;
      chk("drain_load_data",  out_data,  8'h7E);
      chk("drain_load_valid", out_valid, 1'b1);
      chk("drain_load_prio",  prio,      1'b1);
      step();
      chk("drain_empty_valid", out_valid, 1'b0);
      chk("drain_empty_data",  out_data,  8'h7E);
      chk("drain_empty_sel",   out_sel,   1'b0);

      // Asynchronous reset while holding 0x55
      in0_valid = 1'b1; in0_data = 8'h55;
      step();
      in0_valid = 1'b0; out_ready = 1'b0;
      chk("arst_pre_data",  out_data,  8'h55);
      chk("arst_pre_valid", out_valid, 1'b1);
      chk("arst_pre_prio",  prio,      1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_out_data",  out_data,  8'h00);
      chk("arst_prio",      prio,      1'b0);
      chk("arst_out_sel",   out_sel,   1'b0);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("arst_after_valid", out_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
